// File: rtl/hazard_detect_unit.sv
// Pipeline hazard detector: load-use / ALU-to-branch bubbles, taken-branch flush,
// and slow-memory freeze with a bounded wait and sticky timeout flag.
module hazard_detect_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUsesRt,
  input  logic        idBranch,
  input  logic        idTaken,
  input  logic        exMemRead,
  input  logic        exRegWrite,
  input  logic [4:0]  exRt,
  input  logic [4:0]  exRd,
  input  logic        memStart,
  input  logic        memReady,
  output logic [1:0]  hazType,
  output logic        memTimeout,
  output logic [15:0] stallCycles,
  output logic [15:0] flushCount
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, BR_STALL} state_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_timeout;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_load_use;
  logic        w_alu_br;
  logic        w_set_timeout;
  logic [1:0]  w_prio;
  logic [1:0]  w_haz;

  assign w_load_use = exMemRead && (exRt != 5'd0) &&
                      ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
  assign w_alu_br   = idBranch && exRegWrite && (exRd != 5'd0) &&
                      ((exRd == idRs) || (exRd == idRt));

  // Priorities below the memory freeze; a stall always masks idTaken.
  always_comb begin
    w_prio = 2'b00;
    if (w_load_use || w_alu_br) w_prio = 2'b01;
    else if (idTaken)           w_prio = 2'b10;
  end

  always_comb begin
    w_next        = r_state;
    w_haz         = 2'b00;
    w_set_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (memStart && !memReady) begin
          w_haz  = 2'b11;
          w_next = MEM_WAIT;
        end else begin
          w_haz = w_prio;
          if (w_load_use && idBranch) w_next = BR_STALL;
        end
      end
      MEM_WAIT: begin
        if (!memReady) begin
          w_haz = 2'b11;
          if (r_wait_cnt == LP_LAST_WAIT) begin
            w_next        = IDLE;
            w_set_timeout = 1'b1;
          end
        end else begin
          w_haz  = w_prio;
          w_next = IDLE;
        end
      end
      BR_STALL: begin
        w_haz  = 2'b01;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      // The IDLE cycle that raises the freeze is count 0, so the first MEM_WAIT cycle is 1.
      if (r_state == IDLE && w_next == MEM_WAIT)
        r_wait_cnt <= 8'd1;
      else if (r_state == MEM_WAIT && w_next == MEM_WAIT)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      else
        r_wait_cnt <= 8'd0;
      if (w_set_timeout) r_mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_haz[0] && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_haz == 2'b10 && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign hazType     = rst ? 2'b00 : w_haz;
  assign memTimeout  = r_mem_timeout;
  assign stallCycles = r_stall_cnt;
  assign flushCount  = r_flush_cnt;

endmodule
